// File: rtl/blake3_msg_sched_if.sv
// Handshake bundle between the message scheduler, its block source
// and the BLAKE3 round stage.
interface blake3_msg_sched_if #(
  parameter int TAG_W = 32
);
  logic             Valid_I;
  logic             Ready_O;
  logic [511:0]     M_I;
  logic [TAG_W-1:0] Tag_I;
  logic             Valid_O;
  logic             Ready_I;
  logic [511:0]     M_O;
  logic [2:0]       Round_O;
  logic             Last_O;
  logic [TAG_W-1:0] Tag_O;
  logic             Busy_O;

  modport slave (
    input  Valid_I, M_I, Tag_I, Ready_I,
    output Ready_O, Valid_O, M_O, Round_O,
    output Last_O, Tag_O, Busy_O
  );

  modport master (
    output Valid_I, M_I, Tag_I, Ready_I,
    input  Ready_O, Valid_O, M_O, Round_O,
    input  Last_O, Tag_O, Busy_O
  );
endinterface

// File: rtl/blake3_msg_sched.sv
// Iterative BLAKE3 message schedule: one permute register walked
// through NUM_ROUNDS rounds per accepted 16-word block.
module blake3_msg_sched #(
  parameter int NUM_ROUNDS = 7,
  parameter int TAG_W      = 32
) (
  input  logic Clk,
  input  logic Rst_n,
  blake3_msg_sched_if.slave bus
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [2:0] LAST_RND = 3'(NUM_ROUNDS - 1);
  localparam int P [16] = '{
    2, 6, 3, 10, 7, 0, 4, 13,
    1, 11, 12, 5, 9, 14, 15, 8
  };

  state_t           state_q, state_d;
  logic [511:0]     m_q, m_d, m_perm;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [2:0]       rnd_q, rnd_d;
  logic             last;
  logic             ready;

  assign last = (state_q == RUN) && (rnd_q == LAST_RND);

  // Next-round words are a fixed word shuffle of the current ones.
  always_comb begin
    m_perm = '0;
    for (int i = 0; i < 16; i++) begin
      m_perm[32*i +: 32] = m_q[32*P[i] +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    tag_d   = tag_q;
    rnd_d   = rnd_q;
    ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.Valid_I) begin
          m_d     = bus.M_I;
          tag_d   = bus.Tag_I;
          rnd_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.Ready_I) begin
          if (last) begin
            ready = 1'b1;
            if (bus.Valid_I) begin
              m_d   = bus.M_I;
              tag_d = bus.Tag_I;
              rnd_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            m_d   = m_perm;
            rnd_d = rnd_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      tag_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      tag_q   <= tag_d;
      rnd_q   <= rnd_d;
    end
  end

  assign bus.Ready_O = ready;
  assign bus.Valid_O = (state_q == RUN);
  assign bus.Busy_O  = (state_q == RUN);
  assign bus.Last_O  = last;
  assign bus.M_O     = m_q;
  assign bus.Round_O = rnd_q;
  assign bus.Tag_O   = tag_q;

endmodule

// File: doc/blake3_msg_sched.md
Name: blake3_msg_sched

Overview:
- Upstream message-schedule stage for the BLAKE3 round datapath.
- Accepts one 16-word message block per hash attempt and presents the BLAKE3-permuted message words for each of the 7 rounds, one round per accepted transfer.
- Its outputs drive the M0..M15 inputs of the round stage.
- Iterative: a single 512-bit permute register plus a round counter, so the round datapath needs no per-round message wiring.

Parameters:
NUM_ROUNDS, 7, number of rounds emitted per block (legal 2..8)
TAG_W, 32, width of the side-band tag (nonce/job id) carried with each block

Ports:
Clk  in  1  rising-edge clock
Rst_n  in  1  synchronous active-low reset, sampled on Clk rising edge
Valid_I  in  1  input block valid
Ready_O  out  1  scheduler can accept a block this cycle
M_I  in  512  message block; word i = M_I[32*i+31:32*i], i=0..15
Tag_I  in  TAG_W  tag accompanying the block
Valid_O  out  1  M_O/Round_O/Tag_O valid
Ready_I  in  1  round stage consumes the current round words
M_O  out  512  message words for round Round_O, same packing as M_I
Round_O  out  3  round index 0..NUM_ROUNDS-1
Last_O  out  1  high when Round_O == NUM_ROUNDS-1 and Valid_O
Tag_O  out  TAG_W  tag of the block in flight
Busy_O  out  1  high in RUN state

Behaviour:
- Interface: one clock Clk; reset Rst_n is synchronous and active-low.
- Reset (Rst_n=0 at a Clk edge): state=IDLE, Valid_O=0, Last_O=0, Busy_O=0, Round_O=0, M_O=0, Tag_O=0. Ready_O is combinational, so it reads 1 after reset. Reset mid-block discards the block; no partial rounds are emitted afterwards.
- States: IDLE, RUN.
- Ready_O = (state==IDLE) | (state==RUN & Last_O & Ready_I). The back-to-back path is combinational from Ready_I.
- IDLE: on Valid_I & Ready_O, load M_I into the permute register, load Tag_I, set Round_O=0, go to RUN. Valid_O rises the next cycle, so latency from input accept to round-0 valid is 1 cycle. M_O for round 0 equals M_I unchanged.
- RUN: Valid_O=1. While Valid_O & !Ready_I, M_O, Round_O, Tag_O and Last_O hold stable.
- On Valid_O & Ready_I & !Last_O:
  - permute register m'[i] = m[P[i]], with P = {2,6,3,10,7,0,4,13,1,11,12,5,9,14,15,8};
  - Round_O increments.
  - The permutation is pure wiring; no arithmetic.
- On Valid_O & Ready_I & Last_O:
  - if Valid_I is also high (simultaneous accept), load the new block and tag, set Round_O=0, stay in RUN. Valid_O stays high with no bubble.
  - otherwise go to IDLE and Valid_O falls next cycle.
- Round_O never exceeds NUM_ROUNDS-1; there is no wrap without a new block load.
- Tag_O is constant for all rounds of a block.
- Valid_I while RUN and not on the last-round transfer is not accepted (Ready_O=0). The upstream holds the block.
- Throughput: one block per NUM_ROUNDS cycles with Ready_I tied high.

Test Plan:
- Reset then load M_I word i = i, Tag_I=0xA5 -> cycle+1: Valid_O=1, Round_O=0, M_O word0=0, word15=15, Tag_O=0xA5, Ready_O=0.
- Ready_I=1 continuously, same block -> round1 words 0..3 = 2,6,3,10; round2 words 0..1 = 3,4; Last_O=1 only at Round_O=6; Valid_O=0 the cycle after the round-6 transfer.
- Ready_I=0 for 5 cycles at Round_O=3 -> M_O, Round_O, Tag_O unchanged across all 5 cycles; the round resumes at 4 once Ready_I=1.
- Second block (words 0x100+i, Tag 0x5A) presented with Valid_I=1 during round 6 with Ready_I=1 -> Ready_O=1 that cycle; next cycle Round_O=0, M_O word0=0x100, Tag_O=0x5A, no idle cycle.
- Rst_n=0 for one cycle at Round_O=4 -> next cycle Valid_O=0, Round_O=0, Busy_O=0, Ready_O=1; no further rounds of the old block appear.
- Randomized block compared against a software BLAKE3 message schedule over 1000 blocks with random Ready_I stalls -> all rounds match, each block's rounds appear once, in order.
